// File: rtl/systolic_pkg.sv
// Shared types for the systolic matrix multiplier: FSM state encoding and
// the minimum accumulator width needed to hold an N-term dot product.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_COMPUTE,
        ST_OUTPUT
    } state_t;

    function automatic int min_acc_w(input int n, input int data_w);
        return 2 * data_w + $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_param_if.sv
// Job control, input-beat and result-beat handshake bundle for systolic_param.
// master = job source / result sink, slave = the multiplier.
interface systolic_param_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic                  start;
    logic                  signed_mode;
    logic                  accumulate;
    logic                  in_valid;
    logic                  in_ready;
    logic [N*DATA_W-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*ACC_W-1:0]    out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        output start, signed_mode, accumulate, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  start, signed_mode, accumulate, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/systolic_pe.sv
// Output-stationary MAC cell: forwards A right and B down with one register each.
// Operands are sign/zero-extended to ACC_W so the low ACC_W product bits are exact.
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [ACC_W-1:0]  o_c
);
    logic [DATA_W-1:0] r_a, r_b;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_ax, w_bx, w_prod;

    assign w_ax   = {{(ACC_W-DATA_W){i_signed & i_a[DATA_W-1]}}, i_a};
    assign w_bx   = {{(ACC_W-DATA_W){i_signed & i_b[DATA_W-1]}}, i_b};
    assign w_prod = w_ax * w_bx;

    // Forwarding registers drain to zero outside COMPUTE so a new job starts clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            r_a <= i_en ? i_a : '0;
            r_b <= i_en ? i_b : '0;
            if (i_clr)
                r_acc <= '0;
            else if (i_en)
                r_acc <= r_acc + w_prod;
        end
    end

    assign o_a = r_a;
    assign o_b = r_b;
    assign o_c = r_acc;
endmodule

// File: rtl/systolic_param.sv
// N x N systolic matrix multiply C (+)= A*B; loads N A rows then N B columns,
// first result row 3N cycles after the last B beat; rows held until out_ready.
module systolic_param
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    systolic_param_if.slave bus
);
    localparam int IW       = $clog2(N);
    localparam int CW       = $clog2(3 * N);
    localparam int LAST_CNT = 3 * N - 2;

    if (N < 2 || N > 16) begin : g_n_chk
        $error("systolic_param: N must be in 2..16");
    end
    if (ACC_W < min_acc_w(N, DATA_W)) begin : g_acc_chk
        $error("systolic_param: ACC_W too narrow for N and DATA_W");
    end

    state_t               r_state;
    logic [IW-1:0]        r_beat, r_row;
    logic [CW-1:0]        r_cnt;
    logic                 r_signed, r_accum;
    logic                 r_out_vld, r_out_last, r_done;
    logic [N*ACC_W-1:0]   r_out_dat;
    logic [DATA_W-1:0]    r_a [N][N];
    logic [DATA_W-1:0]    r_b [N][N];

    logic                 w_in_hs, w_beat_last, w_cnt_last, w_row_last, w_en, w_clr;
    logic [IW-1:0]        w_sel;
    logic [N*ACC_W-1:0]   w_row;
    logic [DATA_W-1:0]    w_a_feed [N];
    logic [DATA_W-1:0]    w_b_feed [N];
    logic [DATA_W-1:0]    w_a_in   [N][N];
    logic [DATA_W-1:0]    w_b_in   [N][N];
    logic [DATA_W-1:0]    w_a_fwd  [N][N];
    logic [DATA_W-1:0]    w_b_fwd  [N][N];
    logic [ACC_W-1:0]     w_c      [N][N];

    assign w_in_hs     = bus.in_valid && (r_state == ST_LOAD_A || r_state == ST_LOAD_B);
    assign w_beat_last = (r_beat == IW'(N - 1));
    assign w_cnt_last  = (r_cnt == CW'(LAST_CNT));
    assign w_row_last  = (r_row == IW'(N - 1));
    assign w_en        = (r_state == ST_COMPUTE);
    // Clear lands on the same edge that enters COMPUTE.
    assign w_clr       = (r_state == ST_LOAD_B) && w_in_hs && w_beat_last && !r_accum;

    // Skewed edge feed: row i / column i sees element k = cnt - i.
    always_comb begin
        int k;
        k = 0;
        for (int i = 0; i < N; i++) begin
            w_a_feed[i] = '0;
            w_b_feed[i] = '0;
            k = int'(r_cnt) - i;
            if (w_en && k >= 0 && k < N) begin
                w_a_feed[i] = r_a[i][k[IW-1:0]];
                w_b_feed[i] = r_b[k[IW-1:0]][i];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign w_a_in[gi][gj] = w_a_feed[gi];
            end else begin : g_a_link
                assign w_a_in[gi][gj] = w_a_fwd[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign w_b_in[gi][gj] = w_b_feed[gj];
            end else begin : g_b_link
                assign w_b_in[gi][gj] = w_b_fwd[gi-1][gj];
            end
            systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk     (clk),
                .reset   (reset),
                .i_en    (w_en),
                .i_clr   (w_clr),
                .i_signed(r_signed),
                .i_a     (w_a_in[gi][gj]),
                .i_b     (w_b_in[gi][gj]),
                .o_a     (w_a_fwd[gi][gj]),
                .o_b     (w_b_fwd[gi][gj]),
                .o_c     (w_c[gi][gj])
            );
        end
    end

    // Current row when loading the first beat, next row when advancing.
    assign w_sel = r_row + IW'(r_out_vld && !w_row_last);
    always_comb begin
        w_row = '0;
        for (int j = 0; j < N; j++)
            w_row[j*ACC_W +: ACC_W] = w_c[w_sel][j];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_beat     <= '0;
            r_cnt      <= '0;
            r_row      <= '0;
            r_signed   <= 1'b0;
            r_accum    <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_last <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    r_a[i][j] <= '0;
                    r_b[i][j] <= '0;
                end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_state  <= ST_LOAD_A;
                    r_signed <= bus.signed_mode;
                    r_accum  <= bus.accumulate;
                    r_beat   <= '0;
                end
                ST_LOAD_A: if (w_in_hs) begin
                    for (int j = 0; j < N; j++)
                        r_a[r_beat][j] <= bus.in_data[j*DATA_W +: DATA_W];
                    r_beat <= w_beat_last ? '0 : r_beat + IW'(1);
                    if (w_beat_last) r_state <= ST_LOAD_B;
                end
                ST_LOAD_B: if (w_in_hs) begin
                    for (int j = 0; j < N; j++)
                        r_b[j][r_beat] <= bus.in_data[j*DATA_W +: DATA_W];
                    r_beat <= w_beat_last ? '0 : r_beat + IW'(1);
                    if (w_beat_last) begin
                        r_state <= ST_COMPUTE;
                        r_cnt   <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (w_cnt_last) begin
                        r_state <= ST_OUTPUT;
                        r_cnt   <= '0;
                        r_row   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (!r_out_vld) begin
                        r_out_vld  <= 1'b1;
                        r_out_dat  <= w_row;
                        r_out_last <= w_row_last;
                    end else if (bus.out_ready) begin
                        if (w_row_last) begin
                            r_state    <= ST_IDLE;
                            r_out_vld  <= 1'b0;
                            r_out_dat  <= '0;
                            r_out_last <= 1'b0;
                            r_row      <= '0;
                            r_done     <= 1'b1;
                        end else begin
                            r_row      <= r_row + IW'(1);
                            r_out_dat  <= w_row;
                            r_out_last <= (r_row + IW'(1) == IW'(N - 1));
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    assign bus.out_valid = r_out_vld;
    assign bus.out_data  = r_out_dat;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
endmodule

// File: tb/tb_systolic_param.sv
// Directed bench for systolic_param (N=4): hand-computed results, latency,
// output stall, mid-compute reset and a randomised signed/unsigned accumulate pair.
module tb_systolic_param;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_param_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus ();

    systolic_param #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] ga   [N][N];
    logic [DW-1:0] gb   [N][N];
    logic [AW-1:0] gexp [N][N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [AW-1:0] cv);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ga[i][j]   = av;
                gb[i][j]   = bv;
                gexp[i][j] = cv;
            end
    endtask

    task automatic model(input bit sm, input bit acc);
        logic [AW-1:0] s;
        int av, bv;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = acc ? gexp[i][j] : '0;
                for (int k = 0; k < N; k++) begin
                    av = sm ? int'($signed(ga[i][k])) : int'(ga[i][k]);
                    bv = sm ? int'($signed(gb[k][j])) : int'(gb[k][j]);
                    s  = s + AW'(av * bv);
                end
                gexp[i][j] = s;
            end
    endtask

    task automatic load_job(input bit sm, input bit acc, input bit gaps);
        int w;
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.accumulate  = acc;
        tick();
        bus.start = 1'b0;
        for (int b = 0; b < 2 * N; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            for (int j = 0; j < N; j++)
                bus.in_data[j*DW +: DW] = (b < N) ? ga[b][j] : gb[j][b-N];
            bus.in_valid = 1'b1;
            w = 0;
            while (!bus.in_ready && w < 20) begin
                tick();
                w++;
            end
            if (w >= 20) chk("in_ready_timeout", 64'(bus.in_ready), 64'(1));
            tick();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(3 * N));
    endtask

    task automatic collect(input string tag, input int stall_row, input bit gaps);
        int w;
        for (int r = 0; r < N; r++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            w = 0;
            while (!bus.out_valid && w < 50) begin
                tick();
                w++;
            end
            chk($sformatf("%s_vld_r%0d", tag, r), 64'(bus.out_valid), 64'(1));
            chk($sformatf("%s_done_early_r%0d", tag, r), 64'(bus.done), 64'(0));
            chk($sformatf("%s_last_r%0d", tag, r), 64'(bus.out_last), 64'(r == N - 1));
            for (int j = 0; j < N; j++)
                chk($sformatf("%s_c%0d%0d", tag, r, j), 64'(bus.out_data[j*AW +: AW]), 64'(gexp[r][j]));
            if (r == stall_row) begin
                for (int c = 0; c < 5; c++) begin
                    tick();
                    for (int j = 0; j < N; j++)
                        chk($sformatf("%s_stall%0d_c%0d%0d", tag, c, r, j),
                            64'(bus.out_data[j*AW +: AW]), 64'(gexp[r][j]));
                end
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        chk({tag, "_done"}, 64'(bus.done), 64'(1));
        chk({tag, "_busy_end"}, 64'(bus.busy), 64'(0));
        chk({tag, "_vld_end"}, 64'(bus.out_valid), 64'(0));
        tick();
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    task automatic set_identity();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ga[i][j]   = (i == j) ? DW'(1) : DW'(0);
                gb[i][j]   = DW'(i + 1);
                gexp[i][j] = AW'(i + 1);
            end
    endtask

    initial begin
        bit saw_vld;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.accumulate  = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        reset           = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data == '0), 64'(1));
        chk("rst_out_last", 64'(bus.out_last), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        reset = 1'b0;
        tick();

        set_identity();
        load_job(1'b0, 1'b0, 1'b0);
        chk("ident_busy", 64'(bus.busy), 64'(1));
        wait_out("ident");
        collect("ident", -1, 1'b0);

        fill(8'h80, 8'h80, 32'd65536);
        load_job(1'b1, 1'b0, 1'b0);
        wait_out("neg128");
        collect("neg128", -1, 1'b0);

        fill(8'hFF, 8'hFF, 32'd260100);
        load_job(1'b0, 1'b0, 1'b0);
        wait_out("u255");
        collect("u255", -1, 1'b0);

        fill(8'd1, 8'd1, 32'd4);
        load_job(1'b0, 1'b0, 1'b0);
        wait_out("ones");
        collect("ones", -1, 1'b0);
        fill(8'd1, 8'd1, 32'd8);
        load_job(1'b0, 1'b1, 1'b0);
        wait_out("ones_acc");
        collect("ones_acc", -1, 1'b0);

        set_identity();
        load_job(1'b0, 1'b0, 1'b0);
        wait_out("stall");
        collect("stall", 1, 1'b0);

        fill(8'd1, 8'd1, 32'd4);
        load_job(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_vld", 64'(bus.out_valid), 64'(0));
        chk("abort_in_ready", 64'(bus.in_ready), 64'(0));
        saw_vld = 1'b0;
        for (int c = 0; c < 3 * N + 4; c++) begin
            tick();
            if (bus.out_valid || bus.done) saw_vld = 1'b1;
        end
        chk("abort_quiet", 64'(saw_vld), 64'(0));
        load_job(1'b0, 1'b1, 1'b0);
        wait_out("post_abort");
        collect("post_abort", -1, 1'b0);

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ga[i][j] = DW'($urandom_range(0, 255));
                gb[i][j] = DW'($urandom_range(0, 255));
            end
        model(1'b1, 1'b0);
        load_job(1'b1, 1'b0, 1'b1);
        wait_out("rnd_s");
        collect("rnd_s", -1, 1'b1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ga[i][j] = DW'($urandom_range(0, 255));
                gb[i][j] = DW'($urandom_range(0, 255));
            end
        model(1'b0, 1'b1);
        load_job(1'b0, 1'b1, 1'b1);
        wait_out("rnd_u_acc");
        collect("rnd_u_acc", -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
